// File: rtl/hps_dma_bridge.sv
// HPS disk DMA word requests -> Avalon-MM master; the HPS is stalled via ioctl_wait while a request is open.
// Optional burst-read prefetch buffer is built only when DMA_PREFETCH_EN is defined.
module hps_dma_bridge #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int BURST    = 4,
  parameter int LED_HOLD = 4500000
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic [AW-1:0] dma_addr,
  input  logic          dma_rd,
  input  logic          dma_wr,
  input  logic [DW-1:0] dma_dout,
  input  logic          dma_device,
  input  logic          abort,
  output logic [DW-1:0] dma_din,
  output logic          ioctl_wait,
  output logic          overrun,
  output logic [AW-1:0] avm_address,
  output logic          avm_read,
  output logic          avm_write,
  output logic [DW-1:0] avm_writedata,
  output logic [DW/8-1:0] avm_byteenable,
  output logic [7:0]    avm_burstcount,
  input  logic          avm_waitrequest,
  input  logic [DW-1:0] avm_readdata,
  input  logic          avm_readdatavalid,
  output logic          led_fdd,
  output logic          led_hdd
);
  localparam int BE = DW / 8;
  localparam int BL = $clog2(BE);
  localparam int CW = $clog2(BURST) + 1;
  localparam int LW = $clog2(LED_HOLD + 1);
`ifdef DMA_PREFETCH_EN
  localparam int WL  = $clog2(BURST);
  localparam int BLK = BL + WL;
  localparam logic [CW-1:0] NBEAT = CW'(BURST);
`else
  localparam logic [CW-1:0] NBEAT = CW'(1);
`endif

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_BEAT, WR_REQ, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          wait_q, wait_d, ovr_q, ovr_d, rd_q, rd_d, wr_q, wr_d, abt_q, abt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, din_q, din_d;
  logic [7:0]    bc_q, bc_d;
  logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [LW-1:0] ledf_q, ledh_q;
  logic          accept;
  logic          unused_lsb;

  assign unused_lsb = ^dma_addr[BL-1:0];

`ifdef DMA_PREFETCH_EN
  logic              vld_q, vld_d;
  logic [AW-BLK-1:0] tag_q, tag_d;
  logic [DW-1:0]     buf_q [BURST];
  logic              hit;

  assign hit = vld_q && (dma_addr[AW-1:BLK] == tag_q);

  always_ff @(posedge clk_sys) begin
    if (state_q == RD_BEAT && avm_readdatavalid) buf_q[cnt_q[WL-1:0]] <= avm_readdata;
  end
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ovr_d   = ovr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    abt_d   = abt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    din_d   = din_q;
    bc_d    = bc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    accept  = 1'b0;
`ifdef DMA_PREFETCH_EN
    vld_d   = vld_q;
    tag_d   = tag_q;
`endif
    if ((dma_rd || dma_wr) && wait_q) ovr_d = 1'b1;
    case (state_q)
      IDLE: begin
        // wait_q can only be high here for the single cycle of a buffer hit
        wait_d = 1'b0;
        if (!wait_q && dma_wr) begin
          accept  = 1'b1;
          if (dma_rd) ovr_d = 1'b1;
          state_d = WR_REQ;
          wait_d  = 1'b1;
          wr_d    = 1'b1;
          addr_d  = {dma_addr[AW-1:BL], {BL{1'b0}}};
          wdata_d = dma_dout;
          bc_d    = 8'd1;
`ifdef DMA_PREFETCH_EN
          if (dma_addr[AW-1:BLK] == tag_q) vld_d = 1'b0;
`endif
        end else if (!wait_q && dma_rd) begin
          accept = 1'b1;
          wait_d = 1'b1;
          abt_d  = 1'b0;
`ifdef DMA_PREFETCH_EN
          if (hit) begin
            din_d = buf_q[dma_addr[BLK-1:BL]];
          end else begin
            state_d = RD_REQ;
            rd_d    = 1'b1;
            addr_d  = {dma_addr[AW-1:BLK], {BLK{1'b0}}};
            bc_d    = 8'(BURST);
            idx_d   = {1'b0, dma_addr[BLK-1:BL]};
            vld_d   = 1'b0;
            tag_d   = dma_addr[AW-1:BLK];
          end
`else
          state_d = RD_REQ;
          rd_d    = 1'b1;
          addr_d  = {dma_addr[AW-1:BL], {BL{1'b0}}};
          bc_d    = 8'd1;
          idx_d   = '0;
`endif
        end
      end
      WR_REQ: begin
        if (!avm_waitrequest) begin
          wr_d    = 1'b0;
          wait_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        // an abort cannot retract a posted command; remember it until acceptance
        if (abort) abt_d = 1'b1;
        if (!avm_waitrequest) begin
          rd_d    = 1'b0;
          cnt_d   = '0;
          state_d = (abort || abt_q) ? DRAIN : RD_BEAT;
        end
      end
      RD_BEAT, DRAIN: begin
        if (avm_readdatavalid) begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == RD_BEAT && cnt_q == idx_q) din_d = avm_readdata;
          if (cnt_d == NBEAT) begin
            state_d = IDLE;
            wait_d  = 1'b0;
`ifdef DMA_PREFETCH_EN
            vld_d   = (state_q == RD_BEAT) && !abort;
`endif
          end
        end
        if (abort && state_q == RD_BEAT && state_d == RD_BEAT) state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
`ifdef DMA_PREFETCH_EN
    if (abort && state_q != IDLE) vld_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wait_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      abt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      din_q   <= '0;
      bc_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
`ifdef DMA_PREFETCH_EN
      vld_q   <= 1'b0;
      tag_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ovr_q   <= ovr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      abt_q   <= abt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
      bc_q    <= bc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
`ifdef DMA_PREFETCH_EN
      vld_q   <= vld_d;
      tag_q   <= tag_d;
`endif
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ledf_q <= '0;
      ledh_q <= '0;
    end else begin
      if (accept && !dma_device) ledf_q <= LW'(LED_HOLD);
      else if (ledf_q != '0)     ledf_q <= ledf_q - LW'(1);
      if (accept && dma_device)  ledh_q <= LW'(LED_HOLD);
      else if (ledh_q != '0)     ledh_q <= ledh_q - LW'(1);
    end
  end

  assign dma_din        = din_q;
  assign ioctl_wait     = wait_q;
  assign overrun        = ovr_q;
  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_burstcount = bc_q;
  assign avm_byteenable = {BE{rd_q | wr_q}};
  assign led_fdd        = (ledf_q != '0);
  assign led_hdd        = (ledh_q != '0);
endmodule

// File: tb/tb_hps_dma_bridge.sv
// Directed + randomized bench for hps_dma_bridge; the bench plays the Avalon slave and
// predicts results from a word-addressed memory model and the prefetch-window rules.
`timescale 1ns/1ps
module tb_hps_dma_bridge;
  localparam int DW = 32, AW = 32, BURST = 4, LED_HOLD = 20;
`ifdef DMA_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  localparam int NB = PF ? BURST : 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, dma_rd, dma_wr, dma_device, abort;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_dout, dma_din, avm_writedata, avm_readdata;
  logic          ioctl_wait, overrun, avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [AW-1:0] avm_address;
  logic [3:0]    avm_byteenable;
  logic [7:0]    avm_burstcount;
  logic          led_fdd, led_hdd;

  hps_dma_bridge #(.DW(DW), .AW(AW), .BURST(BURST), .LED_HOLD(LED_HOLD)) dut (
    .clk_sys(clk), .reset_n(reset_n), .dma_addr(dma_addr), .dma_rd(dma_rd), .dma_wr(dma_wr),
    .dma_dout(dma_dout), .dma_device(dma_device), .abort(abort), .dma_din(dma_din),
    .ioctl_wait(ioctl_wait), .overrun(overrun), .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .led_fdd(led_fdd), .led_hdd(led_hdd));

  int n_chk = 0, n_err = 0;
  int rd_acc = 0, wr_acc = 0;
  logic [31:0] mem [int unsigned];
  bit          pf_vld = 1'b0;
  int unsigned pf_base = 0;

  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest)  rd_acc <= rd_acc + 1;
    if (avm_write && !avm_waitrequest) wr_acc <= wr_acc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] memrd(input int unsigned w);
    if (mem.exists(w)) return mem[w];
    return (w * 32'h0100_0193) ^ 32'h5BD1_E995;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wait"}, ioctl_wait, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_rd"}, avm_read, 0);
    chk({tag, "_wr"}, avm_write, 0);
    chk({tag, "_addr"}, avm_address, 0);
    chk({tag, "_wdata"}, avm_writedata, 0);
    chk({tag, "_bc"}, avm_burstcount, 0);
    chk({tag, "_be"}, avm_byteenable, 0);
    chk({tag, "_din"}, dma_din, 0);
    chk({tag, "_ledf"}, led_fdd, 0);
    chk({tag, "_ledh"}, led_hdd, 0);
  endtask

  // mode 0: plain write; 1: dma_rd in the same cycle; 2: dma_rd pulse while stalled
  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input int nw,
                       input logic dev, input int mode);
    int acc0, racc0;
    acc0 = wr_acc;
    racc0 = rd_acc;
    @(negedge clk);
    dma_addr = a; dma_dout = d; dma_wr = 1'b1; dma_device = dev; dma_rd = (mode == 1);
    @(negedge clk);
    dma_wr = 1'b0; dma_rd = 1'b0;
    chk("wr_wait_hi", ioctl_wait, 1);
    chk("wr_cmd", avm_write, 1);
    chk("wr_nord", avm_read, 0);
    chk("wr_addr", avm_address, a & 32'hFFFF_FFFC);
    chk("wr_data", avm_writedata, d);
    chk("wr_bc", avm_burstcount, 1);
    chk("wr_be", avm_byteenable, 4'hF);
    for (int i = 0; i < nw; i++) begin
      if (mode == 2 && i == 0) dma_rd = 1'b1;
      @(negedge clk);
      dma_rd = 1'b0;
      chk("wr_hold", avm_write, 1);
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    avm_waitrequest = 1'b1;
    chk("wr_wait_lo", ioctl_wait, 0);
    chk("wr_cmd_lo", avm_write, 0);
    chk("wr_count", wr_acc, acc0 + 1);
    chk("wr_no_rd", rd_acc, racc0);
    mem[a >> 2] = d;
    if (PF && pf_vld && ((a >> 2) / BURST) * BURST == pf_base) pf_vld = 1'b0;
  endtask

  // abort_at < 0: no abort; otherwise abort pulses after that many beats
  task automatic do_rd(input logic [31:0] a, input int dly, input int abort_at);
    int unsigned word, base;
    bit hit;
    logic [31:0] exp;
    int acc0;
    word = a >> 2;
    base = PF ? (word / BURST) * BURST : word;
    hit  = PF && pf_vld && (base == pf_base);
    exp  = memrd(word);
    acc0 = rd_acc;
    @(negedge clk);
    dma_addr = a; dma_rd = 1'b1; dma_device = 1'b0;
    @(negedge clk);
    dma_rd = 1'b0;
    chk("rd_wait_hi", ioctl_wait, 1);
    if (hit) begin
      chk("hit_no_cmd", avm_read, 0);
      chk("hit_data", dma_din, exp);
      @(negedge clk);
      chk("hit_wait_1cyc", ioctl_wait, 0);
      chk("hit_no_avm", rd_acc, acc0);
    end else begin
      chk("rd_cmd", avm_read, 1);
      chk("rd_addr", avm_address, base << 2);
      chk("rd_bc", avm_burstcount, NB);
      chk("rd_be", avm_byteenable, 4'hF);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      avm_waitrequest = 1'b0;
      @(negedge clk);
      avm_waitrequest = 1'b1;
      chk("rd_cmd_lo", avm_read, 0);
      pf_vld = 1'b0;
      for (int i = 0; i < NB; i++) begin
        if (i == abort_at) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
        end
        repeat (dly) @(negedge clk);
        avm_readdatavalid = 1'b1;
        avm_readdata = memrd(base + i);
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        chk("rd_wait_beat", ioctl_wait, (i == NB - 1) ? 0 : 1);
      end
      chk("rd_count", rd_acc, acc0 + 1);
      if (abort_at < 0) begin
        chk("rd_data", dma_din, exp);
        pf_vld = PF;
        pf_base = base;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; dma_rd = 1'b0; dma_wr = 1'b0; dma_device = 1'b0; abort = 1'b0;
    dma_addr = '0; dma_dout = '0; avm_waitrequest = 1'b1; avm_readdata = '0;
    avm_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;

    // write with 3 stall cycles, HDD LED
    do_wr(32'h1000, 32'hDEAD_BEEF, 3, 1'b1, 0);
    chk("led_hdd_on", led_hdd, 1);
    chk("led_fdd_off", led_fdd, 0);
    chk("ovr_clean", overrun, 0);

    // floppy LED stretch: reload on request, dark after LED_HOLD cycles
    do_wr(32'h1004, $urandom, 0, 1'b0, 0);
    repeat (16) @(negedge clk);
    chk("led_fdd_held", led_fdd, 1);
    repeat (5) @(negedge clk);
    chk("led_fdd_expired", led_fdd, 0);

    // read with 5-cycle data latency, then reads in the same window
    mem[32'h2004 >> 2] = 32'h1234_5678;
    do_rd(32'h2004, 5, -1);
    do_rd(32'h2008, 1, -1);
    do_rd(32'h200C, 0, -1);

    // write into the window then re-read: fresh data
    do_wr(32'h2008, $urandom, 1, 1'b0, 0);
    do_rd(32'h2008, 2, -1);

    // randomized traffic in a small region
    for (int k = 0; k < 10; k++) begin
      logic [31:0] a;
      a = 32'h3000 + ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 2) == 0) do_wr(a, $urandom, $urandom_range(0, 3), 1'($urandom), 0);
      else                           do_rd(a, $urandom_range(0, 2), -1);
    end

    // simultaneous rd+wr: write proceeds, read dropped
    chk("ovr_before_both", overrun, 0);
    do_wr(32'h4000, $urandom, 1, 1'b0, 1);
    chk("ovr_both", overrun, 1);

    // reset asserted mid-burst
    @(negedge clk);
    dma_addr = 32'h6004; dma_rd = 1'b1; dma_device = 1'b0;
    @(negedge clk);
    dma_rd = 1'b0;
    chk("mid_cmd", avm_read, 1);
    avm_waitrequest = 1'b0;
    @(negedge clk);
    avm_waitrequest = 1'b1;
    for (int i = 0; i < NB - 1 && i < 1; i++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = $urandom;
      @(negedge clk);
      avm_readdatavalid = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1 chk_zero("rst_mid");
    pf_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // abort with beats outstanding; next read to the same address must miss
    do_rd(32'h5004, 1, PF ? 2 : 0);
    chk("abort_wait_lo", ioctl_wait, 0);
    do_rd(32'h5004, 0, -1);
    chk("ovr_after_reset", overrun, 0);

    // request while stalled: ignored, overrun sticky
    do_wr(32'h5008, $urandom, 2, 1'b1, 2);
    chk("ovr_busy", overrun, 1);
    do_rd(32'h5008, 0, -1);
    chk("ovr_sticky", overrun, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
